// File: rtl/parallel_sorter_ctrl.sv
// Serial-in / serial-out frame sequencer around a parallel sorter datapath.
// Define PARALLEL_SORTER_CTRL_FRAME_CNT_EN to add the frame_cnt output.
module parallel_sorter_ctrl #(
   parameter int data_width   = 3,
   parameter int num_elem     = 2,
   parameter int sort_latency = 1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [data_width-1:0]          in_data,
   input  logic                           in_valid,
   output logic                           in_ready,
   output logic [data_width-1:0]          out_data,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic                           out_last,
   output logic [num_elem*data_width-1:0] srt_inps,
   input  logic [num_elem*data_width-1:0] srt_outp,
   output logic                           busy
`ifdef PARALLEL_SORTER_CTRL_FRAME_CNT_EN
   ,
   output logic [15:0]                    frame_cnt
`endif
);

   localparam int FW = num_elem * data_width;
   localparam int CW = (num_elem > 1) ? $clog2(num_elem) : 1;
   localparam int WW = (sort_latency > 0) ? $clog2(sort_latency + 1) : 1;

   localparam logic [1:0] ST_LOAD  = 2'd0;
   localparam logic [1:0] ST_SORT  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   localparam logic [CW-1:0] LAST_SLOT = CW'(num_elem - 1);
   localparam logic [WW-1:0] LAST_WAIT = WW'(sort_latency);

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] idx_q, idx_d;
   logic [WW-1:0] wait_q, wait_d;
   logic [FW-1:0] srt_inps_q, srt_inps_d;
   logic [FW-1:0] res_q, res_d;
   logic          in_ready_q, in_ready_d;
   logic          out_valid_q, out_valid_d;
   logic          in_hs;
   logic          out_hs;
`ifdef PARALLEL_SORTER_CTRL_FRAME_CNT_EN
   logic [15:0]   frame_q, frame_d;
`endif

   assign in_hs  = in_valid & in_ready_q;
   assign out_hs = out_valid_q & out_ready;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      wait_d      = wait_q;
      srt_inps_d  = srt_inps_q;
      res_d       = res_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
`ifdef PARALLEL_SORTER_CTRL_FRAME_CNT_EN
      frame_d     = frame_q;
`endif
      unique case (1'b1)
         (state_q == ST_LOAD): begin
            in_ready_d = 1'b1;
            if (in_hs) begin
               srt_inps_d[cnt_q*data_width +: data_width] = in_data;
               if (cnt_q == LAST_SLOT) begin
                  cnt_d      = '0;
                  in_ready_d = 1'b0;
                  state_d    = ST_SORT;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         (state_q == ST_SORT): begin
            // Single capture per frame once the sorter output has settled
            if (wait_q == LAST_WAIT) begin
               res_d       = srt_outp;
               wait_d      = '0;
               out_valid_d = 1'b1;
               state_d     = ST_DRAIN;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         (state_q == ST_DRAIN): begin
            if (out_hs) begin
               if (idx_q == LAST_SLOT) begin
                  idx_d       = '0;
                  out_valid_d = 1'b0;
                  in_ready_d  = 1'b1;
                  state_d     = ST_LOAD;
`ifdef PARALLEL_SORTER_CTRL_FRAME_CNT_EN
                  frame_d     = frame_q + 16'd1;
`endif
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_LOAD;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_LOAD;
         cnt_q       <= '0;
         idx_q       <= '0;
         wait_q      <= '0;
         srt_inps_q  <= '0;
         res_q       <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
`ifdef PARALLEL_SORTER_CTRL_FRAME_CNT_EN
         frame_q     <= '0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         wait_q      <= wait_d;
         srt_inps_q  <= srt_inps_d;
         res_q       <= res_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
`ifdef PARALLEL_SORTER_CTRL_FRAME_CNT_EN
         frame_q     <= frame_d;
`endif
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = res_q[idx_q*data_width +: data_width];
   assign out_last  = out_valid_q & (idx_q == LAST_SLOT);
   assign srt_inps  = srt_inps_q;
   assign busy      = (state_q != ST_LOAD) | (cnt_q != '0);
`ifdef PARALLEL_SORTER_CTRL_FRAME_CNT_EN
   assign frame_cnt = frame_q;
`endif

endmodule
